// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear, registered readback and per-bit hardware blink.
// Define PIO_OUT_BLINK_TOGGLE_EN to enable the TOGGLE register at address 5.
module pio_out_blink #(
  parameter int          DATA_WIDTH  = 18,
  parameter int          DIV_WIDTH   = 24,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_MASK   = 3'd3;
  localparam logic [2:0] A_DIV    = 3'd4;
  localparam logic [2:0] A_TOGGLE = 3'd5;

  bus_req_t req;
  assign req.wr    = chipselect & ~write_n;
  assign req.rd    = chipselect & ~read_n;
  assign req.addr  = address;
  assign req.wdata = writedata;

  logic [DATA_WIDTH-1:0] data_q, data_d, mask_q, wd_data;
  logic [DIV_WIDTH-1:0]  div_q, cnt_q, wd_div;
  logic                  phase_q;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign wd_data = req.wdata[DATA_WIDTH-1:0];
  assign wd_div  = req.wdata[DIV_WIDTH-1:0];
  // Bits above the target register width are intentionally dropped.
  assign unused_wdata = ^req.wdata;

  always_comb begin
    data_d = data_q;
    if (req.wr) begin
      case (req.addr)
        A_DATA:   data_d = wd_data;
        A_SET:    data_d = data_q | wd_data;
        A_CLR:    data_d = data_q & ~wd_data;
`ifdef PIO_OUT_BLINK_TOGGLE_EN
        A_TOGGLE: data_d = data_q ^ wd_data;
`endif
        default:  data_d = data_q;
      endcase
    end
  end

  // Read mux sees pre-write register values, so a same-edge read+write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      A_DATA, A_SET, A_CLR: rd_mux = 32'(data_q);
      A_MASK:               rd_mux = 32'(mask_q);
      A_DIV:                rd_mux = 32'(div_q);
`ifdef PIO_OUT_BLINK_TOGGLE_EN
      A_TOGGLE:             rd_mux = 32'(data_q);
`endif
      default:              rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE[DATA_WIDTH-1:0];
      mask_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      readdata <= '0;
    end else begin
      data_q <= data_d;
      if (req.wr && req.addr == A_MASK) mask_q <= wd_data;
      if (req.rd) readdata <= rd_mux;
      // Reprogramming the divider restarts the blink from phase 0.
      if (req.wr && req.addr == A_DIV) begin
        div_q   <= wd_div;
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (div_q == '0) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q == '0) begin
        cnt_q   <= div_q;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q - DIV_WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    assign out_port[i] = data_q[i] ^ (mask_q[i] & phase_q);
  end

endmodule

// File: tb/tb_pio_out_blink.sv
// Scoreboard bench for pio_out_blink: driver pushes expected out_port/readdata, monitor pops and compares.
module tb_pio_out_blink;
  localparam int          DW   = 18;
  localparam int          DIVW = 24;
  localparam logic [31:0] RV   = 32'h0;
  localparam longint unsigned DM   = (64'd1 << DW) - 1;
  localparam longint unsigned DIVM = (64'd1 << DIVW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic          read_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  always #5 clk = ~clk;

  pio_out_blink #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_out_q[$];
  logic [31:0]   exp_rd_q[$];
  logic          rd_flag = 1'b0;

  // Reference model: register values plus edges elapsed since the blink was last restarted.
  longint unsigned m_data, m_mask, m_div, m_k;

  function automatic longint unsigned reg_val(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return m_data;
      3'd3: return m_mask;
      3'd4: return m_div;
`ifdef PIO_OUT_BLINK_TOGGLE_EN
      3'd5: return m_data;
`endif
      default: return 0;
    endcase
  endfunction

  // Phase toggles first one edge after restart, then every div+1 edges.
  function automatic bit phase_now();
    if (m_div == 0) return 1'b0;
    return (((m_k + m_div) / (m_div + 1)) % 2) == 1;
  endfunction

  task automatic step(input bit rst, input bit cs, input bit wn, input bit rn,
                      input logic [2:0] a, input logic [31:0] wd);
    bit wr, rd;
    longint unsigned pre, w;
    reset_n = ~rst; chipselect = cs; write_n = wn; read_n = rn;
    address = a; writedata = wd;
    wr = cs & ~wn;
    rd = cs & ~rn;
    @(posedge clk);
    pre = reg_val(a);
    w = longint'(wd);
    if (rst) begin
      m_data = longint'(RV) & DM; m_mask = 0; m_div = 0; m_k = 0;
      if (rd) exp_rd_q.push_back(32'h0);
    end else begin
      if (rd) exp_rd_q.push_back(32'(pre));
      if (wr) begin
        case (a)
          3'd0: m_data = w & DM;
          3'd1: m_data = (m_data | w) & DM;
          3'd2: m_data = m_data & ~w & DM;
          3'd3: m_mask = w & DM;
          3'd4: m_div  = w & DIVM;
`ifdef PIO_OUT_BLINK_TOGGLE_EN
          3'd5: m_data = (m_data ^ w) & DM;
`endif
          default: ;
        endcase
      end
      if (wr && a == 3'd4) m_k = 0;
      else m_k = m_k + 1;
    end
    exp_out_q.push_back(DW'(m_data ^ (phase_now() ? m_mask : 64'd0)));
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rdc(input logic [2:0] a);
    step(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  // Monitor: out_port every cycle, readdata in the cycle after a read strobe.
  logic [DW-1:0] e_out;
  logic [31:0]   e_rd;
  always @(posedge clk) rd_flag <= chipselect & ~read_n;
  always @(negedge clk) begin
    if (exp_out_q.size() > 0) begin
      e_out = exp_out_q.pop_front();
      checks++;
      if (out_port !== e_out) begin
        errors++;
        $display("FAIL out_port got=%h exp=%h t=%0t", out_port, e_out, $time);
      end
    end
    if (rd_flag) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL readdata no expected value t=%0t", $time);
      end else begin
        e_rd = exp_rd_q.pop_front();
        if (readdata !== e_rd) begin
          errors++;
          $display("FAIL readdata got=%h exp=%h t=%0t", readdata, e_rd, $time);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 32'h0);
    wr(3'd0, 32'h2AAAA); rdc(3'd0);
    // set/clear and reserved addresses
    wr(3'd0, 32'hF0); wr(3'd1, 32'h3); wr(3'd2, 32'hF0); rdc(3'd1); rdc(3'd2);
    wr(3'd6, 32'h3FFFF); rdc(3'd6); wr(3'd7, 32'hFFFFFFFF); rdc(3'd7); rdc(3'd0);
    // blink timing and divider rewrite mid-count
    wr(3'd0, 32'h0); wr(3'd3, 32'h1); wr(3'd4, 32'h3); idle(18);
    wr(3'd4, 32'h1); idle(10); rdc(3'd4); rdc(3'd3);
    // blink disabled
    wr(3'd4, 32'h0); wr(3'd3, 32'h3FFFF); wr(3'd0, 32'h15555); idle(100);
    // sync reset during a write, then async glitch between edges
    wr(3'd4, 32'h2); wr(3'd3, 32'hFF); idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h3FFFF);
    rdc(3'd0); rdc(3'd3); rdc(3'd4);
    wr(3'd4, 32'h2); wr(3'd3, 32'hFF); idle(3);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    idle(1); rdc(3'd3); rdc(3'd4);
    // toggle register (or reserved when disabled)
    wr(3'd0, 32'hF0F); wr(3'd5, 32'hFF); rdc(3'd5); rdc(3'd0);
    // same-edge read+write, and strobes without chipselect
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3FFFF);
    rdc(3'd0); wr(3'd0, 32'hFFFFFFFF); rdc(3'd0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd4) d = $urandom_range(0, 6);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end
    idle(2);
    @(negedge clk);
    checks++;
    if (exp_out_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover out=%0d rd=%0d", exp_out_q.size(), exp_rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_out_blink.md
Name: pio_out_blink

Overview:
- Parametrised successor to the fixed-width red/green LED output PIO.
- Avalon-MM slave driving a DATA_WIDTH-bit output port.
- Adds atomic bit set/clear, registered readback, and per-bit hardware blink from a programmable prescaler, so LEDs flash without CPU involvement.
- Sits on the system interconnect next to the existing PIOs; out_port goes straight to board pins.

Parameters:
- DATA_WIDTH, 18, width of out_port and of the data/mask registers; legal range 1..32.
- DIV_WIDTH, 24, width of the blink prescaler; legal range 1..32.
- RESET_VALUE, 0, value loaded into DATA at reset. Only the low DATA_WIDTH bits are used.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on rising clk.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- read_n  input  1  active-low read strobe, qualified by chipselect.
- writedata  input  32  write data. Bits above the target register width are ignored.
- readdata  output  32  read data. Registered; unused upper bits read 0.
- out_port  output  DATA_WIDTH  pin output.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low (reset_n low at a rising clk edge).
  - Reset values: DATA=RESET_VALUE, BLINK_MASK=0, BLINK_DIV=0, counter=0, phase=0, readdata=0, out_port=RESET_VALUE.
  - Reset asserted mid-operation overrides any concurrent access at that edge.
- Write strobe: wr = chipselect & ~write_n. Read strobe: rd = chipselect & ~read_n.
- Register map:
  - 0 DATA (rw): wr loads writedata[DATA_WIDTH-1:0].
  - 1 SET (wo): wr does DATA |= writedata bits.
  - 2 CLR (wo): wr does DATA &= ~writedata bits.
  - 3 BLINK_MASK (rw): bits set here blink.
  - 4 BLINK_DIV (rw): prescaler reload value, DIV_WIDTH bits.
  - 5 TOGGLE: see Optional Feature.
  - 6, 7: reserved. Writes are ignored; reads return 0.
  - SET, CLR and TOGGLE read back as current DATA.
- Write latency: a register written at edge N holds its new value after edge N. out_port reflects it from the same cycle.
- Read latency is 1 cycle: rd at edge N gives readdata valid after edge N. readdata holds its value until the next rd. No wait states.
- Blink engine:
  - BLINK_DIV == 0: counter and phase held at 0; blinking disabled.
  - BLINK_DIV != 0:
    - counter == 0: reload counter to BLINK_DIV and toggle phase.
    - otherwise: counter decrements by 1.
  - phase period is 2*(BLINK_DIV+1) clk cycles.
  - A write to BLINK_DIV clears counter and phase to 0 on the same edge; a new count starts the next cycle.
  - Writes to BLINK_MASK do not disturb counter or phase.
- Output: out_port = DATA ^ (BLINK_MASK & {DATA_WIDTH{phase}}). Purely combinational from registers, so there are no glitch-producing inputs.
- Simultaneous read and write to the same address at the same edge: readdata returns the pre-write value.
- Only one write per cycle is possible, so there is no SET/CLR conflict.

Optional Feature:
- Macro: PIO_OUT_BLINK_TOGGLE_EN.
- Defined:
  - Address 5 TOGGLE (wo): wr does DATA ^= writedata bits.
  - Reads of address 5 return DATA.
- Undefined:
  - Address 5 is reserved. Writes are ignored; reads return 0.
  - No XOR logic on DATA.

Test Plan:
- Reset and write: reset_n=0 for 2 clk → out_port=0, readdata=0. Write DATA=0x2AAAA → out_port=0x2AAAA next cycle; read addr 0 → readdata=0x0002AAAA after 1 cycle.
- Set/clear: DATA=0x00F0; SET 0x0003 → 0x00F3; CLR 0x00F0 → 0x0003. Read addr 1 → 0x0003. Write addr 6 → DATA unchanged, read addr 6 → 0.
- Blink timing: DATA=0, MASK=0x1, DIV=3 → out_port[0] toggles every 4 cycles, period 8. Bits 17..1 stay 0. Rewrite DIV=1 mid-count → phase=0 immediately, then toggles every 2 cycles.
- Blink disable: DIV=0 with MASK=0x3FFFF, DATA=0x15555 → out_port constant 0x15555 for ≥100 cycles.
- Synchronous reset mid-blink: DIV=2, MASK=0xFF, pulse reset_n low for 1 cycle during a write → next cycle all registers at reset values and the write is discarded. An asynchronous reset_n pulse between edges has no effect.
- Toggle (macro defined): DATA=0x0F0F, write addr 5 = 0x00FF → DATA=0x0FF0. Macro undefined: same write leaves 0x0F0F and read addr 5 returns 0.
